// File: rtl/id_skid_decode.sv
// id_skid_decode: decode-side pipeline buffer between fetch and the
// immediate extender / register-file read.
//
// Fetched instruction + PC pairs arrive over a valid/ready handshake and are
// held in a two-entry skid buffer (main + skid). The main entry is the head
// and drives the pre-split instruction fields. in_ready is a register derived
// from the next state, so fetch never sees a combinational path from
// out_ready. A flush discards everything held plus any same-cycle input.
//
// Optional build macro: ID_STALL_CNT_EN adds the stall_cnt output, a
// saturating count of cycles where a valid head entry is not consumed.
module id_skid_decode #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [5:0]         out_opcode,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_shamt,
  output logic [5:0]         out_funct,
  output logic [15:0]        out_imm16,
  output logic               out_imm_unsigned
`ifdef ID_STALL_CNT_EN
  ,
  output logic [15:0]        stall_cnt
`endif
);

  // Buffer occupancy states
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // Opcodes whose 16-bit immediate is zero-extended (ANDI, ORI, XORI, LUI)
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  logic [1:0]         state;
  logic [1:0]         state_nxt;

  logic [INSTR_W-1:0] main_instr;
  logic [PC_W-1:0]    main_pc;
  logic               main_uns;

  logic [INSTR_W-1:0] skid_instr;
  logic [PC_W-1:0]    skid_pc;
  logic               skid_uns;

  logic               in_xfer;
  logic               out_xfer;
  logic               load_main;
  logic               load_skid;
  logic               move_skid;
  logic               in_uns;

  // Extender control is decided once, when the entry is captured
  function automatic logic imm_is_unsigned(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI) || (op == OP_LUI);
  endfunction

  assign in_uns    = imm_is_unsigned(in_instr[31:26]);
  assign out_valid = (state != ST_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Next-state and datapath steering; flush overrides every transfer
  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_xfer) begin
            load_main = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            load_main = 1'b1;
          end else if (in_xfer) begin
            load_skid = 1'b1;
            state_nxt = ST_FULL;
          end else if (out_xfer) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            move_skid = 1'b1;
            state_nxt = ST_ONE;
          end
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  // State register and registered in_ready, looked up from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      in_ready <= 1'b1;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt != ST_FULL);
    end
  end

  // Head entry: fresh input when it becomes head directly, else the skid entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_instr <= '0;
      main_pc    <= '0;
      main_uns   <= 1'b0;
    end else if (load_main) begin
      main_instr <= in_instr;
      main_pc    <= in_pc;
      main_uns   <= in_uns;
    end else if (move_skid) begin
      main_instr <= skid_instr;
      main_pc    <= skid_pc;
      main_uns   <= skid_uns;
    end
  end

  // Skid entry catches the input that arrives while the head is blocked
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_uns   <= 1'b0;
    end else if (load_skid) begin
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
      skid_uns   <= in_uns;
    end
  end

  assign out_pc           = main_pc;
  assign out_opcode       = main_instr[31:26];
  assign out_rs           = main_instr[25:21];
  assign out_rt           = main_instr[20:16];
  assign out_rd           = main_instr[15:11];
  assign out_shamt        = main_instr[10:6];
  assign out_funct        = main_instr[5:0];
  assign out_imm16        = main_instr[15:0];
  assign out_imm_unsigned = main_uns;

`ifdef ID_STALL_CNT_EN
  // Saturating count of head-blocked cycles; only reset clears it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule
